// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the eight {R,G,B} colours
package vga_pkg;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BACK_DEF = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BACK_DEF = 33;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] CYAN = 3'b011;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] WHITE = 3'b111;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-N counter advancing on en; wrap pulses when en meets N-1
module mod_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = en && count == W'(N - 1);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA scan counters with registered, mutually aligned sync/colour/blank outputs
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_end
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic h_wrap, v_wrap_unused, vis;
  mod_counter #(.N(H_TOTAL), .W(10)) h_cnt (
    .clk(clk), .rst(rst), .en(pix_ce), .count(x), .wrap(h_wrap)
  );
  mod_counter #(.N(V_TOTAL), .W(10)) v_cnt (
    .clk(clk), .rst(rst), .en(h_wrap), .count(y), .wrap(v_wrap_unused)
  );
  assign vis = x < H_VIS && y < V_VIS;
  always_ff @(posedge clk)
    if (rst) begin
      rgb <= BLACK;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b0;
      frame_end <= 1'b0;
    end else if (pix_ce) begin
      rgb <= vis ? rgb_in : BLACK;
      hsync <= !(x >= HS_LO && x <= HS_HI);
      vsync <= !(y >= VS_LO && y <= VS_HI);
      video_on <= vis;
      frame_end <= x == '0 && y == V_VIS;
    end
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: randomized bench against a pixel-index reference model on a reduced timing
module tb_vga_scan_timing;
  localparam int HV = 20, HF = 4, HS = 6, HB = 5;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  logic clk = 0, rst = 1, pix_ce = 0;
  logic [2:0] rgb_in = 0, rgb;
  logic [9:0] x, y;
  logic hsync, vsync, video_on, frame_end;
  int passed = 0, total = 0;
  int mx, my;
  logic [2:0] e_rgb;
  logic e_hs, e_vs, e_vo, e_fe;
  always #5 clk = ~clk;
  vga_scan_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y), .rgb_in(rgb_in),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_end(frame_end)
  );
  function automatic logic [26:0] exp_vec();
    return {10'(mx), 10'(my), e_hs, e_vs, e_vo, e_fe, e_rgb};
  endfunction
  function automatic logic [26:0] act_vec();
    return {x, y, hsync, vsync, video_on, frame_end, rgb};
  endfunction
  task automatic step(input logic r, input logic ce, input logic [2:0] c);
    int p;
    rst = r;
    pix_ce = ce;
    rgb_in = c;
    @(posedge clk);
    if (r) begin
      mx = 0; my = 0; e_rgb = 3'b000; e_hs = 1; e_vs = 1; e_vo = 0; e_fe = 0;
    end else if (ce) begin
      e_vo = mx < HV && my < VV;
      e_rgb = e_vo ? c : 3'b000;
      e_hs = !(mx >= HV + HF && mx < HV + HF + HS);
      e_vs = !(my >= VV + VF && my < VV + VF + VS);
      e_fe = mx == 0 && my == VV;
      p = (my * HT + mx + 1) % FR;
      mx = p % HT;
      my = p / HT;
    end
    #1;
  endtask
  task automatic test_reset();
    step(1, 1, 3'($urandom));
    step(1, 1, 3'($urandom));
    total++;
    if (act_vec() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000})
      $display("FAIL reset_values act=%h exp=%h", act_vec(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000});
    else passed++;
    step(0, 1, 3'($urandom));
    total++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_release act=%h exp=%h", act_vec(), exp_vec());
    else passed++;
  endtask
  task automatic test_line_wrap();
    int py;
    while (mx != HT - 1) begin
      step(0, 1, 3'($urandom));
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL line_run act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
    end
    py = my;
    step(0, 1, 3'($urandom));
    total++;
    if (x !== 10'd0 || y !== 10'((py + 1) % VT))
      $display("FAIL line_wrap act=%0d,%0d exp=0,%0d", x, y, (py + 1) % VT);
    else passed++;
  endtask
  task automatic test_visible();
    int vis_ok = 0, leak = 0;
    step(1, 1, 3'b000);
    for (int i = 0; i < FR; i++) begin
      step(0, 1, 3'b101);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL visible_vec act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
      if (video_on && rgb == 3'b101) vis_ok++;
      if (!video_on && rgb != 3'b000) leak++;
    end
    total++;
    if (vis_ok != HV * VV) $display("FAIL visible_count act=%0d exp=%0d", vis_ok, HV * VV);
    else passed++;
    total++;
    if (leak != 0) $display("FAIL blank_leak act=%0d exp=0", leak);
    else passed++;
  endtask
  task automatic test_sync_frame();
    int n = 0, hs_low = 0, vs_low = 0, bad_start = 0;
    logic prev_hs = 1;
    step(1, 1, 3'b000);
    do begin
      step(0, 1, 3'($urandom));
      n++;
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL sync_vec act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (!hsync && prev_hs && x != 10'(HV + HF + 1)) bad_start++;
      prev_hs = hsync;
    end while (!(x == 0 && y == 0) && n < 2 * FR);
    total++;
    if (n != FR) $display("FAIL frame_clocks act=%0d exp=%0d", n, FR);
    else passed++;
    total++;
    if (hs_low != HS * VT) $display("FAIL hsync_low act=%0d exp=%0d", hs_low, HS * VT);
    else passed++;
    total++;
    if (vs_low != VS * HT) $display("FAIL vsync_low act=%0d exp=%0d", vs_low, VS * HT);
    else passed++;
    total++;
    if (bad_start != 0) $display("FAIL hsync_start act=%0d exp=0", bad_start);
    else passed++;
  endtask
  task automatic test_ce_toggle();
    int n = 0;
    step(1, 1, 3'b000);
    do begin
      step(0, n % 2 == 0, 3'($urandom));
      n++;
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL ce_toggle_vec act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
    end while (!(x == 0 && y == 0 && n % 2 == 0) && n < 3 * FR);
    total++;
    if (n != 2 * FR) $display("FAIL ce_frame_clocks act=%0d exp=%0d", n, 2 * FR);
    else passed++;
  endtask
  task automatic test_random();
    step(1, 1, 3'b000);
    for (int i = 0; i < 1500; i++) begin
      step(0, $urandom_range(2) != 0, 3'($urandom));
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL random_vec act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
    end
  endtask
  task automatic test_mid_reset();
    while (!(mx == 13 && my == 6)) step(0, 1, 3'($urandom));
    step(1, 1, 3'($urandom));
    total++;
    if (act_vec() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000})
      $display("FAIL mid_reset act=%h exp=%h", act_vec(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000});
    else passed++;
    step(0, 0, 3'b111);
    total++;
    if (act_vec() !== exp_vec()) $display("FAIL mid_reset_hold act=%h exp=%h", act_vec(), exp_vec());
    else passed++;
    step(0, 1, 3'b110);
    total++;
    if (act_vec() !== exp_vec() || rgb !== 3'b110)
      $display("FAIL mid_reset_restart act=%h exp=%h", act_vec(), exp_vec());
    else passed++;
  endtask
  task automatic test_frame_end();
    int pulses = 0, bad = 0;
    step(1, 1, 3'b000);
    for (int i = 0; i < 3 * FR; i++) begin
      step(0, 1, 3'($urandom));
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL frame_end_vec act=%h exp=%h", act_vec(), exp_vec());
      else passed++;
      if (frame_end) begin
        pulses++;
        if (x != 10'd1 || y != 10'(VV)) bad++;
      end
    end
    total++;
    if (pulses != 3) $display("FAIL frame_end_count act=%0d exp=3", pulses);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL frame_end_pos act=%0d exp=0", bad);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_line_wrap();
    test_visible();
    test_sync_frame();
    test_ce_toggle();
    test_random();
    test_mid_reset();
    test_frame_end();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit, the single system clock; all logic on rising edge.
REQ-010 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-011 SHALL have port pix_ce, input, 1 bit, pixel-rate enable; tie to 1 when clk is the 25 MHz pixel clock.
REQ-012 SHALL have port x, output, 10 bits, current horizontal count, 0..H_TOTAL-1, to the pixel source.
REQ-013 SHALL have port y, output, 10 bits, current vertical count, 0..V_TOTAL-1, to the pixel source.
REQ-014 SHALL have port rgb_in, input, 3 bits, {R,G,B} colour returned combinationally by the pixel source for (x,y).
REQ-015 SHALL have port rgb, output, 3 bits, registered colour to the DAC pins.
REQ-016 SHALL have ports hsync and vsync, outputs, 1 bit each, registered, active-low.
REQ-017 SHALL have port video_on, output, 1 bit, registered, high while rgb carries a visible pixel.
REQ-018 SHALL have port frame_end, output, 1 bit, registered one-pixel pulse marking the start of vertical blanking.

Function
REQ-019 H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
REQ-020 hcount SHALL advance by 1 only on cycles with pix_ce=1; at H_TOTAL-1 it SHALL wrap to 0 and advance vcount.
REQ-021 vcount SHALL wrap from V_TOTAL-1 to 0 in the same cycle that hcount wraps.
REQ-022 With pix_ce=0, counters and all registered outputs SHALL hold their values.
REQ-023 x and y SHALL be driven directly by the counters, with no added latency.
REQ-024 Visible region SHALL be hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-025 rgb SHALL equal rgb_in registered one pixel-enable after (x,y) in the visible region, and 3'b000 outside it, regardless of rgb_in.
REQ-026 hsync SHALL be low for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751), otherwise high.
REQ-027 vsync SHALL be low for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), otherwise high.
REQ-028 hsync, vsync, video_on and rgb SHALL share the same one-pixel latency, so they are mutually aligned.
REQ-029 frame_end SHALL be 1 for exactly one pixel-enable period, registered from hcount=0 and vcount=V_VISIBLE, and 0 otherwise.

Reset
REQ-030 While rst=1 at a clock edge, counters SHALL become 0 and outputs SHALL become rgb=000, hsync=1, vsync=1, video_on=0, frame_end=0.
REQ-031 rst SHALL take priority over pix_ce.
REQ-032 Reset mid-frame SHALL abandon the frame; the first pix_ce after release SHALL produce x=0, y=0.

Structure
REQ-033 The shared package vga_pkg SHALL hold the default timing constants and the eight 3-bit colour constants (BLACK..WHITE).
REQ-034 A single sub-module mod_counter (a parameterised modulo-N counter with enable and wrap pulse) SHALL be instantiated twice, once horizontal and once vertical.

Verification
REQ-035 Scenario 1: rst for 2 cycles, then pix_ce=1 -> x=0, y=0, hsync=1, vsync=1, rgb=000 at release; x=799 -> 0 with y 0 -> 1.
REQ-036 Scenario 2: rgb_in=3'b101 constant -> rgb=101 with video_on=1 at output pixels for x=0..639, and rgb=000 for x=640..799 and for y>=480.
REQ-037 Scenario 3: free run one full frame -> exactly 96 hsync-low pixels per line starting at x=656, exactly 2 vsync-low lines (490, 491), and 420000 clocks per frame.
REQ-038 Scenario 4: pix_ce toggled 1,0,1,0 -> counters and outputs advance only on ce cycles, and a full frame takes 840000 clocks.
REQ-039 Scenario 5: assert rst at x=300, y=200 -> next cycle all reset values, and the frame restarts at 0,0.
REQ-040 Scenario 6: count frame_end pulses over 3 frames -> exactly 3 single-pulse events, each one pixel after the counter reaches x=0, y=480.
